uart_tx: RTL

- UART 8-bit serial transmitter: asynchronous frame, LSB-first, idle-high line.
- Takes one byte per valid/ready handshake and serializes it as start bit, 8 data bits and stop bit(s).
- Runs at the same bit timing as the team's UART receiver (2604 clocks per bit by default), so a TX-to-RX loopback works with no reconfiguration.
- Sits between the command/response logic and the board TX pin.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_baud_counter.sv | 41 ++++
 rtl/uart_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmitter and receiver.
//   DATA_BITS            : payload width of one frame
//   CLKS_PER_BIT_DEFAULT : bit period in clock cycles, common to TX and RX so a
//                          loopback works without reconfiguration
//   tx_state_t           : transmitter FSM encoding
// Build option: UART_TX_PARITY_EN adds the PARITY state and the parity helper.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 2604;

    // state       | meaning
    // IDLE        | line high, ready for a byte
    // START       | start bit (line low) for one bit period
    // DATA        | data bits, LSB first, one bit period each
    // PARITY      | parity bit (only with UART_TX_PARITY_EN)
    // STOP        | stop bit(s), line high
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } tx_state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity when odd == 0: the parity bit makes the total count of ones even.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                         input logic                 odd);
        return (^data) ^ odd;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and wraps; tick is
// high during the terminal-count cycle so the owner can advance on that edge.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous, active-high reset
//   clear  in  restart the period from 0 (used on every state change)
//   enable in  count while high, hold while low
//   tick   out terminal count reached this cycle (qualified by enable)
// ---------------------------------------------------------------------------
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == TERMINAL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8-bit asynchronous serial transmitter: start bit, 8 data bits LSB first,
// optional parity bit, STOP_BITS stop bits. Idle-high line.
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   STOP_BITS    : 1 or 2
//   PARITY_ODD   : 0 = even, 1 = odd (only with UART_TX_PARITY_EN)
// Ports:
//   clock    in   system clock
//   reset    in   asynchronous, active-high reset
//   tx_data  in   byte to send, latched on the accept edge
//   tx_valid in   requester has a byte
//   tx_ready out  accepting a byte this cycle (state IDLE)
//   TX_o     out  serial line, registered
//   busy     out  frame in progress
//   done     out  one-cycle pulse in the first IDLE cycle after a frame
// Build option: UART_TX_PARITY_EN inserts a parity bit before the stop bits.
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    , parameter logic PARITY_ODD = 1'b0
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TX_o,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t            state_q;
    tx_state_t            state_d;
    logic [2:0]           bit_idx_q;
    logic [2:0]           bit_idx_d;
    logic [DATA_BITS-1:0] shift_q;
    logic                 line_d;
    logic                 done_d;
    logic                 accept;
    logic                 baud_tick;
    logic                 baud_clear;

    assign tx_ready   = (state_q == IDLE);
    assign busy       = !tx_ready;
    assign accept     = tx_valid && tx_ready;
    // Restarting the period on every state change keeps each frame aligned to
    // its own accept edge, with no residue carried over from the last frame.
    assign baud_clear = (state_d != state_q);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock  (clock),
        .reset  (reset),
        .clear  (baud_clear),
        .enable (busy),
        .tick   (baud_tick)
    );

    // Next-state, bit index and next line level.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        line_d    = 1'b1;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                end
            end
`endif
            STOP: begin
                // bit_idx counts stop bits here.
                if (baud_tick) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
            end
        endcase

        // The line is registered, so it is derived from the state being entered;
        // TX_o then only moves on bit boundaries and never glitches.
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_d = calc_parity(shift_q, PARITY_ODD);
`endif
            default: line_d = 1'b1;
        endcase

        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            TX_o      <= 1'b1;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            TX_o      <= line_d;
            done      <= done_d;
            if (accept) begin
                shift_q <= tx_data;
            end
        end
    end

endmodule
